uart_tx_fifo: RTL

Parametrised UART transmitter with an internal write FIFO, a configurable data width, runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. It sits between a byte/word producer, such as a CPU CSR bridge or a debug stream, and the TX pin. It lets the producer queue several characters without waiting on each frame, and frames are emitted back-to-back with no idle gap. It is the generalised successor to the plain 8N1 transmitter used elsewhere in the design.

---
 rtl/uart_tx_fifo.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small circular write FIFO; frames run back-to-back.
// Data width, parity mode and one/two stop bits are configurable, and the frame settings are latched per frame.
module uart_tx_fifo #(
    parameter int DIV_WIDTH  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_LOG2  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  valid,
    output logic                  ready,
    input  logic [DIV_WIDTH-1:0]  div,
    input  logic [1:0]            parity,
    input  logic                  stop2,
    output logic                  tx,
    output logic                  busy,
    output logic [FIFO_LOG2:0]    level
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int BW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_LOG2-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_LOG2:0]    count_reg, count_next;

    state_t                state_reg;
    logic [DIV_WIDTH-1:0]  baud_reg, div_reg;
    logic [BW-1:0]         bit_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_reg, par_bit_reg, stop2_reg, stop_left_reg;
    logic                  tx_reg, busy_reg;
    logic                  push, pop, bit_end;

    assign ready   = (count_reg != (FIFO_LOG2+1)'(DEPTH));
    assign push    = valid & ready;
    assign bit_end = (baud_reg == '0);
    // Pop from IDLE, or on the final cycle of the last stop bit so the next start bit follows directly.
    assign pop     = (count_reg != '0) &&
                     ((state_reg == IDLE) || (state_reg == STOP && bit_end && !stop_left_reg));

    assign level = count_reg;
    assign tx    = tx_reg;
    assign busy  = busy_reg;

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + 1'b1;
        else if (!push && pop)
            count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            baud_reg      <= '0;
            div_reg       <= '0;
            bit_reg       <= '0;
            shift_reg     <= '0;
            par_en_reg    <= 1'b0;
            par_bit_reg   <= 1'b0;
            stop2_reg     <= 1'b0;
            stop_left_reg <= 1'b0;
            tx_reg        <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            busy_reg <= (state_reg != IDLE) || (count_next != '0) || pop;

            // tx follows the state one cycle later, so the whole frame shifts uniformly.
            case (state_reg)
                START:   tx_reg <= 1'b0;
                DATA:    tx_reg <= shift_reg[0];
                PAR:     tx_reg <= par_bit_reg;
                default: tx_reg <= 1'b1;
            endcase

            if (pop) begin
                shift_reg   <= mem[rd_ptr_reg];
                div_reg     <= div;
                baud_reg    <= div;
                par_en_reg  <= parity[1];
                par_bit_reg <= (^mem[rd_ptr_reg]) ^ parity[0];
                stop2_reg   <= stop2;
                state_reg   <= START;
            end else begin
                case (state_reg)
                    IDLE: ;
                    START: begin
                        if (bit_end) begin
                            baud_reg  <= div_reg;
                            bit_reg   <= BW'(DATA_WIDTH - 1);
                            state_reg <= DATA;
                        end else begin
                            baud_reg <= baud_reg - 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            baud_reg  <= div_reg;
                            shift_reg <= shift_reg >> 1;
                            if (bit_reg == '0) begin
                                state_reg     <= par_en_reg ? PAR : STOP;
                                stop_left_reg <= stop2_reg;
                            end else begin
                                bit_reg <= bit_reg - 1'b1;
                            end
                        end else begin
                            baud_reg <= baud_reg - 1'b1;
                        end
                    end
                    PAR: begin
                        if (bit_end) begin
                            baud_reg      <= div_reg;
                            stop_left_reg <= stop2_reg;
                            state_reg     <= STOP;
                        end else begin
                            baud_reg <= baud_reg - 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            if (stop_left_reg) begin
                                stop_left_reg <= 1'b0;
                                baud_reg      <= div_reg;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            baud_reg <= baud_reg - 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end
endmodule
